// File: rtl/boost_duty_ramp.sv
// boost_duty_ramp
// Duty-word feeder for the boost PWM stage. Accepts duty commands over a
// valid/ready handshake, clamps them to D_MAX, and slews the registered
// output d_boost toward the clamped target by at most STEP codes on each
// rising edge of the asynchronous control-interrupt tick. A synchronized,
// active-low over-current input forces the duty to zero and latches a fault
// that only an explicit fault_clr (with the fault gone) can release.

module boost_duty_ramp #(
    parameter int DW    = 10,
    parameter int D_MAX = 921,
    parameter int STEP  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          tick,
    input  logic          cmd_valid,
    input  logic [DW-1:0] cmd_duty,
    output logic          cmd_ready,
    input  logic          fault_n,
    input  logic          fault_clr,
    output logic [DW-1:0] d_boost,
    output logic          at_target,
    output logic          fault_latched
);

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Constants sized for the arithmetic they take part in; the step math is
    // done one bit wider than the duty word so nothing wraps near full scale.
    localparam logic [DW-1:0] D_MAX_W  = DW'(D_MAX);
    localparam logic [DW:0]   STEP_W   = (DW+1)'(STEP);
    localparam logic [DW-1:0] STEP_DW  = DW'(STEP);
    localparam logic [DW-1:0] ZERO_DW  = {DW{1'b0}};

    // Clamp a requested duty code to the safe maximum.
    function automatic logic [DW-1:0] clamp_cmd(input logic [DW-1:0] req);
        logic [DW-1:0] res;
        if (req > D_MAX_W) begin
            res = D_MAX_W;
        end else begin
            res = req;
        end
        return res;
    endfunction

    // One bounded slew step from cur toward tgt, never overshooting tgt and
    // never underflowing below it when ramping down.
    function automatic logic [DW-1:0] ramp_step(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] tgt);
        logic [DW:0]   up_sum;
        logic [DW:0]   down_floor;
        logic [DW-1:0] res;
        up_sum     = {1'b0, cur} + STEP_W;
        down_floor = {1'b0, tgt} + STEP_W;
        if (cur < tgt) begin
            if (up_sum > {1'b0, tgt}) begin
                res = tgt;
            end else begin
                res = up_sum[DW-1:0];
            end
        end else if (cur > tgt) begin
            // cur >= tgt + STEP guarantees cur - STEP stays at or above tgt
            if ({1'b0, cur} >= down_floor) begin
                res = cur - STEP_DW;
            end else begin
                res = tgt;
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Synchronizer and edge-detect flops
    logic tick_s1_r;
    logic tick_s2_r;
    logic tick_s3_r;
    logic flt_s1_r;
    logic flt_s2_r;
    logic tick_re_s;
    logic flt_s;

    // Controller registers
    logic [1:0]    state_r;
    logic [DW-1:0] d_boost_r;
    logic [DW-1:0] target_r;
    logic          cmd_ready_r;
    logic          fault_latched_r;

    // Next-state values
    logic [1:0]    state_nxt_s;
    logic [DW-1:0] d_boost_nxt_s;
    logic [DW-1:0] target_nxt_s;
    logic          handshake_s;

    // Bring the tick square wave into clk domain; third flop feeds edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1_r <= 1'b0;
            tick_s2_r <= 1'b0;
            tick_s3_r <= 1'b0;
        end else begin
            tick_s1_r <= tick;
            tick_s2_r <= tick_s1_r;
            tick_s3_r <= tick_s2_r;
        end
    end

    // Bring the active-low over-current input into clk domain (idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_s1_r <= 1'b1;
            flt_s2_r <= 1'b1;
        end else begin
            flt_s1_r <= fault_n;
            flt_s2_r <= flt_s1_r;
        end
    end

    assign tick_re_s   = tick_s2_r & ~tick_s3_r;
    assign flt_s       = ~flt_s2_r;
    assign handshake_s = cmd_valid & cmd_ready_r;

    // Next-state, duty and target selection with flt > !ce > handshake > tick
    always_comb begin
        state_nxt_s   = state_r;
        d_boost_nxt_s = d_boost_r;
        target_nxt_s  = target_r;
        case (state_r)
            ST_IDLE: begin
                d_boost_nxt_s = ZERO_DW;
                target_nxt_s  = ZERO_DW;
                if (ce && !flt_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flt_s) begin
                    state_nxt_s   = ST_FAULT;
                    d_boost_nxt_s = ZERO_DW;
                    target_nxt_s  = ZERO_DW;
                end else if (!ce) begin
                    // Enable loss drops the duty at once, no ramp-down
                    state_nxt_s   = ST_IDLE;
                    d_boost_nxt_s = ZERO_DW;
                    target_nxt_s  = ZERO_DW;
                end else begin
                    state_nxt_s = ST_RUN;
                    if (handshake_s) begin
                        target_nxt_s = clamp_cmd(cmd_duty);
                    end else begin
                        target_nxt_s = target_r;
                    end
                    // A step coinciding with a new command uses the old target
                    if (tick_re_s) begin
                        d_boost_nxt_s = ramp_step(d_boost_r, target_r);
                    end else begin
                        d_boost_nxt_s = d_boost_r;
                    end
                end
            end
            ST_FAULT: begin
                d_boost_nxt_s = ZERO_DW;
                target_nxt_s  = ZERO_DW;
                if (fault_clr && !flt_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                d_boost_nxt_s = ZERO_DW;
                target_nxt_s  = ZERO_DW;
            end
        endcase
    end

    // Register state, duty word, target and the status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            d_boost_r       <= ZERO_DW;
            target_r        <= ZERO_DW;
            cmd_ready_r     <= 1'b0;
            fault_latched_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            d_boost_r       <= d_boost_nxt_s;
            target_r        <= target_nxt_s;
            cmd_ready_r     <= (state_nxt_s == ST_RUN);
            fault_latched_r <= (state_nxt_s == ST_FAULT);
        end
    end

    assign d_boost       = d_boost_r;
    assign cmd_ready     = cmd_ready_r;
    assign fault_latched = fault_latched_r;
    assign at_target     = (d_boost_r == target_r);

endmodule

// File: tb/tb_boost_duty_ramp.sv
// Directed bench for boost_duty_ramp with hand-computed expectations.

module tb_boost_duty_ramp;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       tick;
    logic       cmd_valid;
    logic [9:0] cmd_duty;
    logic       cmd_ready;
    logic       fault_n;
    logic       fault_clr;
    logic [9:0] d_boost;
    logic       at_target;
    logic       fault_latched;

    int n_checks = 0;
    int n_pass   = 0;

    boost_duty_ramp #(.DW(10), .D_MAX(921), .STEP(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .tick          (tick),
        .cmd_valid     (cmd_valid),
        .cmd_duty      (cmd_duty),
        .cmd_ready     (cmd_ready),
        .fault_n       (fault_n),
        .fault_clr     (fault_clr),
        .d_boost       (d_boost),
        .at_target     (at_target),
        .fault_latched (fault_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One full tick period; the resulting step has landed when this returns
    task automatic tick_pulse();
        @(negedge clk) tick = 1'b1;
        repeat (4) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_cmd(input int v);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_duty  = 10'(v);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Tick until d_boost reaches goal, bounded
    task automatic ramp_to(input string tag, input int goal);
        int n;
        n = 0;
        while (int'(d_boost) != goal && n < 400) begin
            tick_pulse();
            n++;
        end
        chk(tag, int'(d_boost), goal);
    endtask

    initial begin
        rst_n     = 1'b0;
        ce        = 1'b0;
        tick      = 1'b0;
        cmd_valid = 1'b0;
        cmd_duty  = 10'd0;
        fault_n   = 1'b1;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_d", int'(d_boost), 0);
        chk("rst_at", int'(at_target), 1);
        chk("rst_rdy", int'(cmd_ready), 0);
        chk("rst_flt", int'(fault_latched), 0);

        rst_n = 1'b1;
        ce    = 1'b1;
        repeat (3) @(negedge clk);
        chk("run_rdy", int'(cmd_ready), 1);

        // Ramp up to 100 in steps of 4, then hold
        send_cmd(100);
        chk("cmd100_at", int'(at_target), 0);
        for (int i = 1; i <= 30; i++) begin
            tick_pulse();
            chk($sformatf("up_t%0d", i), int'(d_boost), (4 * i > 100) ? 100 : 4 * i);
            if (i == 24) chk("at_t24", int'(at_target), 0);
            if (i == 25) chk("at_t25", int'(at_target), 1);
        end
        chk("up_rdy", int'(cmd_ready), 1);

        // Clamp to D_MAX from 918
        send_cmd(918);
        ramp_to("reach918", 918);
        send_cmd(1023);
        chk("clamp_at", int'(at_target), 0);
        tick_pulse();
        chk("clamp_t1", int'(d_boost), 921);
        tick_pulse();
        chk("clamp_t2", int'(d_boost), 921);
        chk("clamp_at2", int'(at_target), 1);

        // Ramp down from 100 to 2 without underflow
        send_cmd(100);
        ramp_to("reach100", 100);
        send_cmd(2);
        for (int i = 1; i <= 26; i++) begin
            tick_pulse();
            chk($sformatf("dn_t%0d", i), int'(d_boost), (100 - 4 * i < 2) ? 2 : 100 - 4 * i);
        end

        // Fault mid-ramp at 52
        send_cmd(52);
        ramp_to("reach52", 52);
        send_cmd(200);
        @(negedge clk) fault_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("flt_d", int'(d_boost), 0);
        chk("flt_lat", int'(fault_latched), 1);
        chk("flt_rdy", int'(cmd_ready), 0);
        @(negedge clk) fault_clr = 1'b1;
        @(negedge clk) fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("flt_hold", int'(fault_latched), 1);
        fault_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("flt_stay", int'(fault_latched), 1);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        chk("clr_lat", int'(fault_latched), 0);
        chk("clr_idle_rdy", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        chk("clr_run_rdy", int'(cmd_ready), 1);
        chk("clr_run_d", int'(d_boost), 0);

        // Handshake coincident with tick_re: step uses old target 40
        send_cmd(40);
        ramp_to("reach40", 40);
        @(negedge clk) tick = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_duty  = 10'd80;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("coinc_d", int'(d_boost), 40);
        chk("coinc_at", int'(at_target), 0);
        repeat (4) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("coinc_hold", int'(d_boost), 40);
        tick_pulse();
        chk("coinc_next", int'(d_boost), 44);

        // ce drop at 200
        send_cmd(200);
        ramp_to("reach200", 200);
        @(negedge clk) ce = 1'b0;
        @(posedge clk);
        #1;
        chk("ce_d", int'(d_boost), 0);
        chk("ce_rdy", int'(cmd_ready), 0);
        send_cmd(300);
        chk("ce_refuse_at", int'(at_target), 1);
        ce = 1'b1;
        repeat (3) @(negedge clk);
        tick_pulse();
        chk("ce_forgot", int'(d_boost), 0);

        // Asynchronous reset mid-ramp
        send_cmd(100);
        for (int i = 0; i < 3; i++) tick_pulse();
        chk("pre_rst", int'(d_boost), 12);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_d", int'(d_boost), 0);
        chk("arst_rdy", int'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rdy", int'(cmd_ready), 1);
        chk("post_d", int'(d_boost), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
